// File: rtl/sram_responder.sv
// sram_responder: device end of the board's 256K x 16 asynchronous SRAM pin
// interface. Stands in for the physical chip in simulation and FPGA loopback
// builds. Writes honour the byte lanes; reads come back either combinationally
// (READ_LATENCY = 0) or through a READ_LATENCY-deep pipeline (1..4) whose
// stages hold a snapshot of the word taken when the read was captured.
// DATA_WIDTH must stay 16: the lane logic assumes exactly two byte lanes.
//
// Optional build macro SRAM_RESP_STATS_EN adds wr_count, rd_count and a
// sticky contention_err output. The default build has none of them.
module sram_responder #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  inout  wire  [DATA_WIDTH-1:0] SRAM_DQ,
  input  logic                  SRAM_WE_N,
  input  logic                  SRAM_CE_N,
  input  logic                  SRAM_OE_N,
  input  logic                  SRAM_UB_N,
  input  logic                  SRAM_LB_N
`ifdef SRAM_RESP_STATS_EN
  ,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count,
  output logic                  contention_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is deliberately never reset: contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  is_write;
  logic                  is_read;
  logic [DATA_WIDTH-1:0] drive_data;
  logic                  drive_ub;
  logic                  drive_lb;

  // Write wins over OE, so a cycle with both WE_N and OE_N low is a write.
  assign is_write = !SRAM_CE_N && !SRAM_WE_N;
  assign is_read  = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;

  // Per-lane tristate; a lane not explicitly enabled floats.
  assign SRAM_DQ[15:8] = drive_ub ? drive_data[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = drive_lb ? drive_data[7:0]  : 8'bz;

  // Byte-lane write; the edge is ignored while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && is_write) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb
      // Combinational read straight from the array while the bus allows it.
      always_comb begin
        drive_data = mem[SRAM_ADDR];
        drive_ub   = !reset && is_read && !SRAM_UB_N;
        drive_lb   = !reset && is_read && !SRAM_LB_N;
      end
    end else begin : g_pipe
      logic [READ_LATENCY-1:0] pipe_valid;
      logic [READ_LATENCY-1:0] pipe_ub_n;
      logic [READ_LATENCY-1:0] pipe_lb_n;
      logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

      // Valid bits are the only pipeline state that reset has to clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= is_read;
          for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
      end

      // Snapshot of the addressed word and lane enables, shifted every cycle;
      // later writes to the same address cannot touch data already in flight.
      always_ff @(posedge clk) begin
        pipe_data[0] <= mem[SRAM_ADDR];
        pipe_ub_n[0] <= SRAM_UB_N;
        pipe_lb_n[0] <= SRAM_LB_N;
        for (int i = 1; i < READ_LATENCY; i++) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_ub_n[i] <= pipe_ub_n[i-1];
          pipe_lb_n[i] <= pipe_lb_n[i-1];
        end
      end

      // The last stage drives for its single cycle only if the controller is
      // still reading; otherwise the word is silently dropped.
      always_comb begin
        drive_data = pipe_data[READ_LATENCY-1];
        drive_ub   = !reset && is_read && pipe_valid[READ_LATENCY-1] && !pipe_ub_n[READ_LATENCY-1];
        drive_lb   = !reset && is_read && pipe_valid[READ_LATENCY-1] && !pipe_lb_n[READ_LATENCY-1];
      end
    end
  endgenerate

`ifdef SRAM_RESP_STATS_EN
  // Saturating access counters and sticky contention flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count       <= '0;
      rd_count       <= '0;
      contention_err <= 1'b0;
    end else begin
      if (is_write && (!SRAM_UB_N || !SRAM_LB_N) && (wr_count != 32'hFFFF_FFFF))
        wr_count <= wr_count + 32'd1;
      if (is_read && (rd_count != 32'hFFFF_FFFF))
        rd_count <= rd_count + 32'd1;
      // An unresolved lane while we drive it means someone else is driving too.
      if ((drive_ub && $isunknown(SRAM_DQ[15:8])) || (drive_lb && $isunknown(SRAM_DQ[7:0])))
        contention_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: one combinational instance and one with a
// two-cycle read pipeline share the controller pins; each has its own DQ net.
// A lane is observed as {drive enables, visible data}, where data is only
// meaningful on a lane that someone drives.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] addr;
  logic        we_n, ce_n, oe_n, ub_n, lb_n;
  logic        tb_drive;
  logic [15:0] tb_data;
  wire  [15:0] dq0;
  wire  [15:0] dq2;

  assign dq0 = tb_drive ? tb_data : 16'hzzzz;
  assign dq2 = tb_drive ? tb_data : 16'hzzzz;

`ifdef SRAM_RESP_STATS_EN
  logic [31:0] wr0, rd0, wr2, rd2;
  logic        cerr0, cerr2;
`endif

  sram_responder #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .READ_LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .SRAM_ADDR(addr), .SRAM_DQ(dq0),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
`ifdef SRAM_RESP_STATS_EN
    , .wr_count(wr0), .rd_count(rd0), .contention_err(cerr0)
`endif
  );

  sram_responder #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .SRAM_ADDR(addr), .SRAM_DQ(dq2),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
`ifdef SRAM_RESP_STATS_EN
    , .wr_count(wr2), .rd_count(rd2), .contention_err(cerr2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
  } pend_t;

  pend_t       pq[$];
  logic [15:0] model [int];
  int          checks;
  int          errors;
  int          exp_wr;
  int          exp_rd;

  function automatic logic [17:0] pk(input logic eh, input logic el, input logic [15:0] v);
    return {eh, el, eh ? v[15:8] : 8'h00, el ? v[7:0] : 8'h00};
  endfunction

  function automatic logic [17:0] obs0();
    return {u_lat0.drive_ub, u_lat0.drive_lb,
            (u_lat0.drive_ub || tb_drive) ? dq0[15:8] : 8'h00,
            (u_lat0.drive_lb || tb_drive) ? dq0[7:0]  : 8'h00};
  endfunction

  function automatic logic [17:0] obs2();
    return {u_lat2.drive_ub, u_lat2.drive_lb,
            (u_lat2.drive_ub || tb_drive) ? dq2[15:8] : 8'h00,
            (u_lat2.drive_lb || tb_drive) ? dq2[7:0]  : 8'h00};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pipeline depth of invalid entries, as after reset.
  task automatic prime();
    pq.delete();
    pq.push_back('0);
    pq.push_back('0);
  endtask

  // One bus cycle: drive pins, queue the pipelined expectation, check both
  // instances mid-cycle, then retire the write into the model at the edge.
  task automatic step(input logic w_n, input logic c_n, input logic o_n,
                      input logic u_n, input logic l_n,
                      input logic [17:0] a, input logic [15:0] d);
    pend_t       p;
    pend_t       q;
    logic [15:0] m;
    logic        rd;
    logic        wr;
    logic [17:0] e0;
    logic [17:0] e2;
    we_n = w_n; ce_n = c_n; oe_n = o_n; ub_n = u_n; lb_n = l_n;
    addr = a; tb_data = d; tb_drive = !w_n;
    wr = !c_n && !w_n;
    rd = !c_n && w_n && !o_n;
    m  = model.exists(int'(a)) ? model[int'(a)] : 16'h0000;
    p.valid = rd; p.data = m; p.ub_n = u_n; p.lb_n = l_n;
    pq.push_back(p);
    q = pq.pop_front();
    @(negedge clk);
    if (!w_n) begin
      e0 = {2'b00, d};
      e2 = {2'b00, d};
    end else begin
      e0 = pk(rd && !u_n, rd && !l_n, m);
      e2 = pk(rd && q.valid && !q.ub_n, rd && q.valid && !q.lb_n, q.data);
    end
    check("dq_lat0", obs0(), e0);
    check("dq_lat2", obs2(), e2);
    if (wr) begin
      model[int'(a)] = {u_n ? m[15:8] : d[15:8], l_n ? m[7:0] : d[7:0]};
      if (!u_n || !l_n) exp_wr++;
    end
    if (rd) exp_rd++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; exp_wr = 0; exp_rd = 0;
    reset = 1'b1; tb_drive = 1'b0; tb_data = 16'h0000; addr = '0;
    we_n = 1'b1; ce_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    @(posedge clk);
    #1;
    // Read-style pins during reset must not produce any drive.
    check("reset_z_lat0", obs0(), 18'h0);
    check("reset_z_lat2", obs2(), 18'h0);
`ifdef SRAM_RESP_STATS_EN
    check32("reset_wr_count", wr0, 32'd0);
    check32("reset_rd_count", rd2, 32'd0);
`endif
    reset = 1'b0;
    prime();

    // Controller-style 32-bit write as two words, OE_N held low, then read back.
    step(0, 0, 0, 0, 0, 18'd0, 16'hBEEF);
    step(0, 0, 0, 0, 0, 18'd1, 16'hDEAD);
    step(1, 0, 0, 0, 0, 18'd0, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd1, 16'h0000);

    // Byte lanes: upper lane kept, both-lanes-off write ignored, lane-masked read.
    step(0, 0, 0, 0, 0, 18'd5, 16'h1234);
    step(0, 0, 0, 1, 0, 18'd5, 16'hABCD);
    step(0, 0, 0, 1, 1, 18'd5, 16'h5555);
    step(1, 0, 0, 0, 1, 18'd5, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd5, 16'h0000);

    // Write with OE_N low: bench drives, responder must stay off the bus.
    step(0, 0, 0, 0, 0, 18'd6, 16'h5A5A);

    // Preload, then back-to-back reads through the pipeline.
    for (int i = 7; i <= 11; i++) step(0, 0, 0, 0, 0, 18'(i), 16'h0700 + 16'(i));
    for (int i = 7; i <= 11; i++) step(1, 0, 0, 0, 0, 18'(i), 16'h0000);
    step(1, 1, 0, 0, 0, 18'd0, 16'h0000);
    step(1, 1, 0, 0, 0, 18'd0, 16'h0000);

    // Snapshot: write to 7 while its read is in flight; old value must emerge.
    step(1, 0, 0, 0, 0, 18'd7, 16'h0000);
    step(0, 0, 0, 0, 0, 18'd7, 16'hFFFF);
    step(1, 0, 0, 0, 0, 18'd8, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd8, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd7, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd7, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd7, 16'h0000);

    // Lane enables travel with the pipelined read.
    step(1, 0, 0, 1, 0, 18'd5, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd5, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd5, 16'h0000);

    // Reset while the pipelined read of 7 is on the bus.
    step(1, 0, 0, 0, 0, 18'd7, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd8, 16'h0000);
    we_n = 1'b1; ce_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    addr = 18'd9; tb_drive = 1'b0;
    #1;
    check("inflight_lat2", obs2(), pk(1'b1, 1'b1, model[7]));
    reset = 1'b1;
    #1;
    check("midrst_z_lat2", obs2(), 18'h0);
    check("midrst_z_lat0", obs0(), 18'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    prime();
    exp_wr = 0;
    exp_rd = 0;

    // After reset: no stale pipeline data, memory intact, then the stats mix.
    step(1, 0, 0, 0, 0, 18'd0, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd0, 16'h0000);
    step(1, 0, 0, 0, 0, 18'd0, 16'h0000);
    step(0, 0, 0, 0, 0, 18'd20, 16'h2020);
    step(0, 0, 0, 0, 0, 18'd21, 16'h2121);
    step(0, 0, 0, 0, 0, 18'd22, 16'h2222);
    step(0, 0, 0, 1, 1, 18'd20, 16'h9999);
    step(1, 0, 0, 0, 0, 18'd20, 16'h0000);
    step(1, 1, 1, 1, 1, 18'd0, 16'h0000);
    step(1, 1, 1, 1, 1, 18'd0, 16'h0000);

`ifdef SRAM_RESP_STATS_EN
    check32("wr_count_lat0", wr0, 32'(exp_wr));
    check32("rd_count_lat0", rd0, 32'(exp_rd));
    check32("wr_count_lat2", wr2, 32'(exp_wr));
    check32("rd_count_lat2", rd2, 32'(exp_rd));
    check32("wr_count_abs", wr0, 32'd3);
    check32("rd_count_abs", rd2, 32'd4);
    check32("contention_lat0", {31'b0, cerr0}, 32'd0);
    check32("contention_lat2", {31'b0, cerr2}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
